// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the instruction/data cache memory-port arbiter.
// Holds the state encoding, requester IDs and the default bus widths.
package mem_bus_arbiter_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT_I = 2'b01,
    GRANT_D = 2'b10,
    GAP     = 2'b11
  } arb_state_t;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  function automatic logic other_req(input logic id);
    return ~id;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_pick2.sv
// Two-input round-robin picker: on a tie the requester that was not
// granted last wins; otherwise the sole requester is granted.
module rr_pick2
  import mem_bus_arbiter_pkg::*;
(
  input  logic       req_i,
  input  logic       req_d,
  input  logic       last_grant,
  output logic [1:0] grant,
  output logic       valid
);

  always_comb begin
    grant = 2'b00;
    if (req_i && req_d) begin
      grant[other_req(last_grant)] = 1'b1;
    end else if (req_i) begin
      grant[REQ_I] = 1'b1;
    end else if (req_d) begin
      grant[REQ_D] = 1'b1;
    end
  end

  assign valid = req_i | req_d;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one data-memory port between the icache (refills) and the dcache
// (refills and write-backs), one block transaction at a time, round-robin.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              I_Read,
  input  logic [ADDR_W-1:0] I_Address,
  output logic [DATA_W-1:0] I_ReadData,
  output logic              I_BusyWait,
  input  logic              D_Read,
  input  logic              D_Write,
  input  logic [ADDR_W-1:0] D_Address,
  input  logic [DATA_W-1:0] D_WriteData,
  output logic [DATA_W-1:0] D_ReadData,
  output logic              D_BusyWait,
  output logic              Mem_Read,
  output logic              Mem_Write,
  output logic [ADDR_W-1:0] Mem_Address,
  output logic [DATA_W-1:0] Mem_WriteData,
  input  logic [DATA_W-1:0] Mem_ReadData,
  input  logic              Mem_BusyWait
);

  arb_state_t        r_state,      w_state_nxt;
  logic              r_last_grant, w_last_grant_nxt;
  logic              r_started,    w_started_nxt;
  logic              r_mem_read,   w_mem_read_nxt;
  logic              r_mem_write,  w_mem_write_nxt;
  logic [ADDR_W-1:0] r_mem_addr,   w_mem_addr_nxt;
  logic [DATA_W-1:0] r_mem_wdata,  w_mem_wdata_nxt;

  logic       w_req_d;
  logic       w_done;
  logic [1:0] w_grant;
  logic       w_grant_vld;

  assign w_req_d = D_Read | D_Write;
  // Memory must have acknowledged with busy before its low level means completion.
  assign w_done  = r_started & ~Mem_BusyWait;

  rr_pick2 u_pick (
    .req_i      (I_Read),
    .req_d      (w_req_d),
    .last_grant (r_last_grant),
    .grant      (w_grant),
    .valid      (w_grant_vld)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state      <= IDLE;
      r_last_grant <= REQ_I;
      r_started    <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_started    <= w_started_nxt;
      r_mem_read   <= w_mem_read_nxt;
      r_mem_write  <= w_mem_write_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    w_started_nxt    = r_started;
    w_mem_read_nxt   = r_mem_read;
    w_mem_write_nxt  = r_mem_write;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_wdata_nxt  = r_mem_wdata;
    case (r_state)
      IDLE: begin
        if (w_grant_vld) begin
          if (w_grant[REQ_D]) begin
            // A simultaneous read and write from the dcache is a write-back.
            w_state_nxt     = GRANT_D;
            w_mem_write_nxt = D_Write;
            w_mem_read_nxt  = ~D_Write;
            w_mem_addr_nxt  = D_Address;
            w_mem_wdata_nxt = D_WriteData;
          end else begin
            w_state_nxt     = GRANT_I;
            w_mem_write_nxt = 1'b0;
            w_mem_read_nxt  = 1'b1;
            w_mem_addr_nxt  = I_Address;
          end
        end
      end
      GRANT_I, GRANT_D: begin
        if (Mem_BusyWait) begin
          w_started_nxt = 1'b1;
        end
        if (w_done) begin
          w_mem_read_nxt   = 1'b0;
          w_mem_write_nxt  = 1'b0;
          w_started_nxt    = 1'b0;
          w_last_grant_nxt = (r_state == GRANT_D) ? REQ_D : REQ_I;
          w_state_nxt      = GAP;
        end
      end
      GAP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign I_BusyWait    = I_Read  & ~((r_state == GRANT_I) & w_done);
  assign D_BusyWait    = w_req_d & ~((r_state == GRANT_D) & w_done);
  assign I_ReadData    = Mem_ReadData;
  assign D_ReadData    = Mem_ReadData;
  assign Mem_Read      = r_mem_read;
  assign Mem_Write     = r_mem_write;
  assign Mem_Address   = r_mem_addr;
  assign Mem_WriteData = r_mem_wdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios followed by two randomized
// cache agents checked against a transaction-level memory/fairness model.
module tb_mem_bus_arbiter;

  localparam int AW = 6;
  localparam int DW = 32;

  logic          Clk = 1'b0;
  logic          Reset_n;
  logic          I_Read, D_Read, D_Write;
  logic [AW-1:0] I_Address, D_Address;
  logic [DW-1:0] D_WriteData;
  logic [DW-1:0] I_ReadData, D_ReadData;
  logic          I_BusyWait, D_BusyWait;
  logic          Mem_Read, Mem_Write, Mem_BusyWait;
  logic [AW-1:0] Mem_Address;
  logic [DW-1:0] Mem_WriteData, Mem_ReadData;

  int errors = 0;
  int checks = 0;

  // Behavioural memory: busy while a strobe is up until mem_lat edges have passed.
  logic [DW-1:0] mem [64];
  int            mem_lat;
  int            mem_cnt;
  logic          mem_fin;
  logic          last_w;
  logic [AW-1:0] last_a;
  logic [DW-1:0] last_d;

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .I_Read(I_Read), .I_Address(I_Address), .I_ReadData(I_ReadData), .I_BusyWait(I_BusyWait),
    .D_Read(D_Read), .D_Write(D_Write), .D_Address(D_Address), .D_WriteData(D_WriteData),
    .D_ReadData(D_ReadData), .D_BusyWait(D_BusyWait),
    .Mem_Read(Mem_Read), .Mem_Write(Mem_Write), .Mem_Address(Mem_Address),
    .Mem_WriteData(Mem_WriteData), .Mem_ReadData(Mem_ReadData), .Mem_BusyWait(Mem_BusyWait)
  );

  always #5 Clk = ~Clk;

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return 32'hDEADBEEF ^ ({26'd0, a ^ 6'h05} * 32'h01000193);
  endfunction

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mem_cnt      <= 0;
      mem_fin      <= 1'b0;
      Mem_ReadData <= '0;
      last_w       <= 1'b0;
      last_a       <= '0;
      last_d       <= '0;
      for (int i = 0; i < 64; i++) mem[i] <= pat(i[5:0]);
    end else if (Mem_Read || Mem_Write) begin
      if (!mem_fin) begin
        if (mem_cnt + 1 >= mem_lat) begin
          mem_fin <= 1'b1;
          mem_cnt <= 0;
          last_w  <= Mem_Write;
          last_a  <= Mem_Address;
          last_d  <= Mem_WriteData;
          if (Mem_Write) mem[Mem_Address] <= Mem_WriteData;
          else           Mem_ReadData     <= mem[Mem_Address];
        end else begin
          mem_cnt <= mem_cnt + 1;
        end
      end
    end else begin
      mem_cnt <= 0;
      mem_fin <= 1'b0;
    end
  end

  assign Mem_BusyWait = (Mem_Read | Mem_Write) & ~mem_fin;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs until the chosen port sees its done cycle (busy low while requesting).
  // ns counts strobe-high samples, no counts samples where the other port was freed.
  task automatic wait_done(input bit is_d, output int n, output int ns, output int no);
    n = 0; ns = 0; no = 0;
    do begin
      tick();
      n++;
      if (Mem_Read || Mem_Write) ns++;
      if (is_d ? (I_Read && !I_BusyWait) : ((D_Read || D_Write) && !D_BusyWait)) no++;
    end while ((is_d ? D_BusyWait : I_BusyWait) && n < 100);
    chk(is_d ? "d_done_bound" : "i_done_bound", 64'(is_d ? D_BusyWait : I_BusyWait), 64'(0));
  endtask

  logic [DW-1:0] ref_mem [64];
  int            n, ns, no, who, c, low, exp_next, lowrun, bad;
  bit            seen, prev_st;
  bit            i_act, d_act;
  int            i_idle, d_idle, i_wait, d_wait, d_op;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_data;

  initial begin
    Reset_n = 1'b0; I_Read = 1'b0; D_Read = 1'b0; D_Write = 1'b0;
    I_Address = '0; D_Address = '0; D_WriteData = '0; mem_lat = 5;
    repeat (3) tick();
    chk("rst_mem_read",   64'(Mem_Read), 64'(0));
    chk("rst_mem_write",  64'(Mem_Write), 64'(0));
    chk("rst_mem_addr",   64'(Mem_Address), 64'(0));
    chk("rst_mem_wdata",  64'(Mem_WriteData), 64'(0));
    chk("rst_busy",       64'({I_BusyWait, D_BusyWait}), 64'(0));
    Reset_n = 1'b1;
    tick();

    // Reset in the middle of a write-back
    D_Write = 1'b1; D_Address = 6'h11; D_WriteData = 32'hCAFEF00D;
    tick();
    chk("t1_write",   64'({Mem_Write, Mem_Read}), 64'(2'b10));
    chk("t1_addr",    64'(Mem_Address), 64'(6'h11));
    chk("t1_wdata",   64'(Mem_WriteData), 64'(32'hCAFEF00D));
    chk("t1_dbusy",   64'(D_BusyWait), 64'(1));
    tick();
    chk("t1_membusy", 64'(Mem_BusyWait), 64'(1));
    Reset_n = 1'b0;
    #1;
    chk("t1_rst_write", 64'(Mem_Write), 64'(0));
    chk("t1_rst_addr",  64'(Mem_Address), 64'(0));
    D_Write = 1'b0;
    tick();
    Reset_n = 1'b1;
    tick();
    D_Read = 1'b1; D_Address = 6'h11;
    tick();
    chk("t1_regrant", 64'({Mem_Read, Mem_Address}), 64'({1'b1, 6'h11}));
    wait_done(1'b1, n, ns, no);
    chk("t1_rdata",   64'(D_ReadData), 64'(pat(6'h11)));
    D_Read = 1'b0;
    repeat (2) tick();

    // Single icache refill, 5 busy cycles
    I_Read = 1'b1; I_Address = 6'h05;
    tick();
    chk("t2_grant", 64'({Mem_Read, Mem_Write, Mem_Address}), 64'({2'b10, 6'h05}));
    chk("t2_ibusy", 64'(I_BusyWait), 64'(1));
    wait_done(1'b0, n, ns, no);
    chk("t2_read_cycles", 64'(ns + 1), 64'(6));
    chk("t2_rdata",       64'(I_ReadData), 64'(32'hDEADBEEF));
    I_Read = 1'b0;
    tick();
    chk("t2_gap", 64'({Mem_Read, Mem_Write}), 64'(0));

    // Simultaneous requests straight after reset: D wins
    Reset_n = 1'b0;
    tick();
    Reset_n = 1'b1;
    tick();
    I_Read = 1'b1; I_Address = 6'h01; D_Read = 1'b1; D_Address = 6'h22;
    tick();
    chk("t3_first_d", 64'({Mem_Read, Mem_Address}), 64'({1'b1, 6'h22}));
    chk("t3_ibusy",   64'(I_BusyWait), 64'(1));
    wait_done(1'b1, n, ns, no);
    chk("t3_i_stalled", 64'(no), 64'(0));
    chk("t3_d_rdata",   64'(D_ReadData), 64'(pat(6'h22)));
    D_Read = 1'b0;
    tick();
    chk("t3_gap",       64'({Mem_Read, I_BusyWait}), 64'(2'b01));
    tick();
    chk("t3_idle",      64'(Mem_Read), 64'(0));
    tick();
    chk("t3_then_i",    64'({Mem_Read, Mem_Address}), 64'({1'b1, 6'h01}));
    wait_done(1'b0, n, ns, no);
    chk("t3_i_rdata",   64'(I_ReadData), 64'(pat(6'h01)));
    I_Read = 1'b0;
    repeat (2) tick();

    // Continuous contention: D, I, D, I with exactly two idle samples between
    mem_lat = 2;
    I_Read = 1'b1; I_Address = 6'h31;
    D_Read = 1'b1; D_Write = 1'b1; D_Address = 6'h38; D_WriteData = $urandom;
    for (int k = 0; k < 4; k++) begin
      who = -1; c = 0; low = 0;
      while (who < 0 && c < 100) begin
        tick();
        c++;
        if (!(Mem_Read || Mem_Write)) low++;
        if (I_Read && !I_BusyWait) who = 0;
        else if ((D_Read || D_Write) && !D_BusyWait) who = 1;
      end
      chk("rr_order", 64'(who), 64'((k % 2 == 0) ? 1 : 0));
      chk("rr_spacing", 64'(low), 64'((k == 0) ? 0 : 2));
      chk("rr_opcode", 64'(last_w), 64'(who == 1));
      chk("rr_addr", 64'(last_a), 64'((who == 1) ? D_Address : I_Address));
      if (who == 1) begin
        chk("rr_wdata", 64'(last_d), 64'(D_WriteData));
        D_Address = D_Address + 6'd1; D_WriteData = $urandom;
      end else begin
        chk("rr_i_rdata", 64'(I_ReadData), 64'(pat(I_Address)));
        I_Address = I_Address + 6'd1;
      end
    end
    I_Read = 1'b0; D_Read = 1'b0; D_Write = 1'b0;
    repeat (2) tick();

    // Dirty miss: write-back then refill
    mem_lat = 3;
    D_Write = 1'b1; D_Address = 6'h2A; D_WriteData = 32'h12345678;
    tick();
    wait_done(1'b1, n, ns, no);
    chk("t5_wb", 64'({last_w, last_a, last_d}), 64'({1'b1, 6'h2A, 32'h12345678}));
    D_Write = 1'b0; D_Read = 1'b1; D_Address = 6'h0A;
    wait_done(1'b1, n, ns, no);
    chk("t5_refill_latency", 64'(n), 64'(6));
    chk("t5_refill", 64'({last_w, last_a}), 64'({1'b0, 6'h0A}));
    chk("t5_rdata",  64'(D_ReadData), 64'(pat(6'h0A)));
    D_Read = 1'b0;
    repeat (2) tick();
    I_Read = 1'b1; I_Address = 6'h2A;
    tick();
    wait_done(1'b0, n, ns, no);
    chk("t5_readback", 64'(I_ReadData), 64'(32'h12345678));
    I_Read = 1'b0;
    repeat (2) tick();

    // Icache drops its request mid-grant while the dcache waits
    mem_lat = 6;
    I_Read = 1'b1; I_Address = 6'h10;
    tick();
    chk("t6_grant_i", 64'({Mem_Read, Mem_Address}), 64'({1'b1, 6'h10}));
    D_Read = 1'b1; D_Address = 6'h33;
    repeat (2) tick();
    I_Read = 1'b0;
    ns = 3; c = 0; bad = 0;
    while ((Mem_Read || Mem_Write) && c < 50) begin
      tick();
      c++;
      if (Mem_Read || Mem_Write) begin
        ns++;
        if (Mem_Address !== 6'h10) bad++;
      end
      if (D_BusyWait !== 1'b1) bad++;
    end
    chk("t6_held_to_done", 64'(ns), 64'(7));
    chk("t6_held_stable",  64'(bad), 64'(0));
    tick();
    chk("t6_idle", 64'(Mem_Read), 64'(0));
    tick();
    chk("t6_grant_d", 64'({Mem_Read, Mem_Address, D_BusyWait}), 64'({1'b1, 6'h33, 1'b1}));
    wait_done(1'b1, n, ns, no);
    chk("t6_d_rdata", 64'(D_ReadData), 64'(pat(6'h33)));
    D_Read = 1'b0;
    repeat (2) tick();

    // Randomized agents against the transaction-level model
    Reset_n = 1'b0;
    tick();
    Reset_n = 1'b1;
    for (int i = 0; i < 64; i++) ref_mem[i] = pat(i[5:0]);
    i_act = 0; d_act = 0; i_idle = 0; d_idle = 1; i_wait = 0; d_wait = 0;
    exp_next = -1; lowrun = 0; seen = 0; prev_st = 0; mem_lat = 3;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      chk("rnd_strobe_excl", 64'(Mem_Read && Mem_Write), 64'(0));
      if (Mem_Read || Mem_Write) begin
        if (!prev_st && seen) chk("rnd_gap", 64'(lowrun >= 2), 64'(1));
        seen = 1; lowrun = 0; prev_st = 1;
      end else begin
        lowrun++; prev_st = 0;
      end
      if (i_act && !I_BusyWait) begin
        chk("rnd_i_rdata", 64'(I_ReadData), 64'(ref_mem[i_addr]));
        chk("rnd_i_txn",   64'({last_w, last_a}), 64'({1'b0, i_addr}));
        chk("rnd_i_wait",  64'(i_wait <= 20), 64'(1));
        if (exp_next >= 0) chk("rnd_fair", 64'(0), 64'(exp_next));
        exp_next = d_act ? 1 : -1;
        i_act = 0; I_Read = 1'b0; i_idle = $urandom_range(0, 3);
      end else if (d_act && !D_BusyWait) begin
        if (d_op == 0) begin
          chk("rnd_d_rdata", 64'(D_ReadData), 64'(ref_mem[d_addr]));
          chk("rnd_d_rtxn",  64'({last_w, last_a}), 64'({1'b0, d_addr}));
        end else begin
          chk("rnd_d_wtxn",  64'({last_w, last_a, last_d}), 64'({1'b1, d_addr, d_data}));
          ref_mem[d_addr] = d_data;
        end
        chk("rnd_d_wait",  64'(d_wait <= 20), 64'(1));
        if (exp_next >= 0) chk("rnd_fair", 64'(1), 64'(exp_next));
        exp_next = i_act ? 0 : -1;
        d_act = 0; D_Read = 1'b0; D_Write = 1'b0; d_idle = $urandom_range(0, 3);
      end
      if (i_act) i_wait++;
      if (d_act) d_wait++;
      if (!i_act) begin
        if (i_idle == 0) begin
          i_act = 1; i_wait = 0; i_addr = 6'($urandom_range(0, 15));
          I_Read = 1'b1; I_Address = i_addr;
        end else i_idle--;
      end
      if (!d_act) begin
        if (d_idle == 0) begin
          d_act = 1; d_wait = 0; d_op = $urandom_range(0, 2);
          d_addr = 6'($urandom_range(0, 15)); d_data = $urandom;
          D_Read = (d_op != 1); D_Write = (d_op != 0);
          D_Address = d_addr; D_WriteData = d_data;
        end else d_idle--;
      end
      if ($urandom_range(0, 15) == 0) mem_lat = $urandom_range(1, 4);
    end
    I_Read = 1'b0; D_Read = 1'b0; D_Write = 1'b0;
    repeat (10) tick();
    chk("end_quiet", 64'({Mem_Read, Mem_Write, I_BusyWait, D_BusyWait}), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single data-memory port between the instruction cache (read-only refills) and the data cache (refills and write-backs).
- Sits between both cache controllers and data memory, and presents each cache with the same Mem_* handshake the cache already expects.
- Round-robin arbitration at block granularity.
- A memory transaction, once issued, always runs to completion.

Parameters:
- ADDR_W, 6, block address width (8-bit byte address minus 2-bit offset).
- DATA_W, 32, memory block width.

Ports:
- Clk  in  1  system clock; all state updates on posedge.
- Reset_n  in  1  asynchronous, active-low reset.
- I_Read  in  1  icache refill request.
- I_Address  in  ADDR_W  icache block address.
- I_ReadData  out  DATA_W  refill data to icache.
- I_BusyWait  out  1  stall to icache.
- D_Read  in  1  dcache refill request.
- D_Write  in  1  dcache write-back request.
- D_Address  in  ADDR_W  dcache block address.
- D_WriteData  in  DATA_W  dcache write-back data.
- D_ReadData  out  DATA_W  refill data to dcache.
- D_BusyWait  out  1  stall to dcache.
- Mem_Read  out  1  memory read strobe.
- Mem_Write  out  1  memory write strobe.
- Mem_Address  out  ADDR_W  memory block address.
- Mem_WriteData  out  DATA_W  memory write data.
- Mem_ReadData  in  DATA_W  memory read data.
- Mem_BusyWait  in  1  memory busy.

Behaviour:
- Clock and reset: one clock, Clk. Reset_n is asynchronous, active-low.
- Reset values: state=IDLE, last_grant=I (so D wins the first tie), started=0, Mem_Read=0, Mem_Write=0, Mem_Address=0, Mem_WriteData=0.
- Reset mid-transaction: everything is forced to the values above immediately. No completion is signalled.
- State machine: IDLE, GRANT_I, GRANT_D, GAP.
- IDLE:
  - Request only from I: go to GRANT_I.
  - Request only from D (D_Read or D_Write): go to GRANT_D.
  - Both requesting: grant the requester that is not last_grant.
  - The chosen requester's address, opcode and write data are latched into the registered Mem_* outputs on the same edge.
- D opcode: if D_Read and D_Write are both high, it is treated as a write.
- GRANT_x:
  - Mem_* outputs are held stable.
  - started is set on the first posedge where Mem_BusyWait=1.
  - done = started && !Mem_BusyWait (combinational).
  - On the posedge where done=1: Mem_Read/Mem_Write go to 0, last_grant is updated to x, started is cleared, and the state moves to GAP.
- GAP: exactly one cycle with no strobes, so memory sees its request deassert; then go to IDLE. Arbitration resumes from IDLE, so minimum back-to-back spacing is 2 idle cycles.
- Memory latency: no assumption. Any number of busy cycles is legal.
- Busy-wait outputs:
  - x_BusyWait = x_request && !(state==GRANT_x && done), combinational.
  - A requester is therefore stalled from the cycle its request rises until the cycle memory completes its own transaction.
  - While the other requester is being served, it stays stalled.
- Read data: x_ReadData = Mem_ReadData, passed through combinationally to both requesters. It is only meaningful to the grantee in its done cycle.
- Request dropped while granted: the memory transaction continues to completion and the result is discarded. The arbiter then goes through GAP and IDLE as normal.
- Request inputs changing while granted: ignored, because the Mem_* outputs are latched.
- Starvation bound: one transaction of the other requester plus 2 cycles.
- Mem_Write is never asserted for the I port.

Decomposition:
- Shared package: state encoding (IDLE=2'b00, GRANT_I=2'b01, GRANT_D=2'b10, GAP=2'b11), requester IDs (REQ_I=0, REQ_D=1), ADDR_W and DATA_W defaults.
- One natural sub-module, rr_pick2: a 2-input round-robin picker. Inputs are req_i, req_d and last_grant; outputs are the grant one-hot and a valid flag.

Test Plan:
- Reset mid-transaction: D_Write to block 6'h11, assert Reset_n=0 while Mem_BusyWait=1 -> Mem_Write drops to 0 immediately. After release, state=IDLE. A new D_Read is granted first.
- Single refill: I_Read with I_Address=6'h05, memory busy 5 cycles returning 32'hDEADBEEF -> Mem_Address=6'h05, Mem_Read=1 for 6 cycles, I_ReadData=DEADBEEF with I_BusyWait low in the done cycle, then one GAP cycle.
- Simultaneous after reset: I_Read(6'h01) and D_Read(6'h22) together -> D is served first and I_BusyWait stays 1 throughout. Then GAP, then I is served with Mem_Address=6'h01.
- Round-robin fairness: both ports request continuously for 4 transactions -> grant order D, I, D, I, and Mem_Write=0 on every I grant.
- Write-back then refill (dcache dirty miss): D_Write with 6'h2A/32'h12345678, then D_Read 6'h0A -> memory sees the write, GAP, then the read. D_BusyWait deasserts only in each done cycle.
- Request dropped mid-grant: I_Read falls after 2 busy cycles -> Mem_Read held until done, then GAP, IDLE. A pending D request is granted next.
